// File: rtl/hoop_pkg.sv
// Shared types, default thresholds and helpers for the hoop pass/crash detector.
package hoop_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      INSIDE   = 2'd1,
      COOLDOWN = 2'd2
   } hoop_state_t;

   typedef enum {
      CLS_CLEAR,
      CLS_PARTIAL,
      CLS_IN,
      CLS_RIM
   } frame_class_t;

   localparam int CNT_W_DEF             = 16;
   localparam int IN_THRESH_DEF         = 32;
   localparam int RIM_THRESH_DEF        = 4;
   localparam int MIN_INSIDE_FRAMES_DEF = 3;
   localparam int COOLDOWN_FRAMES_DEF   = 30;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? 8'hFF : v + 8'd1;
   endfunction

endpackage

// File: rtl/frame_overlap_counter.sv
// Per-frame rim/interior overlap accumulators; classifies the finished frame at each startOfFrame.
module frame_overlap_counter
   import hoop_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int IN_THRESH  = IN_THRESH_DEF,
   parameter int RIM_THRESH = RIM_THRESH_DEF
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         sof_i,
   input  logic         rim_pix_i,
   input  logic         in_pix_i,
   output frame_class_t class_o,
   output logic         class_valid_o
);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] IN_TH    = CNT_W'(IN_THRESH);
   localparam logic [CNT_W-1:0] RIM_TH   = CNT_W'(RIM_THRESH);

   logic [CNT_W-1:0] rim_cnt_q, rim_cnt_d;
   logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
   logic             frame_valid_q;
   frame_class_t     class_s;

   // A pixel on the startOfFrame cycle already belongs to the new frame.
   always_comb begin
      rim_cnt_d = rim_cnt_q;
      in_cnt_d  = in_cnt_q;
      if (sof_i) begin
         rim_cnt_d = rim_pix_i ? CNT_ONE : CNT_ZERO;
         in_cnt_d  = in_pix_i ? CNT_ONE : CNT_ZERO;
      end else begin
         if (rim_pix_i && (rim_cnt_q != CNT_MAX)) begin
            rim_cnt_d = rim_cnt_q + CNT_ONE;
         end else begin
            rim_cnt_d = rim_cnt_q;
         end
         if (in_pix_i && (in_cnt_q != CNT_MAX)) begin
            in_cnt_d = in_cnt_q + CNT_ONE;
         end else begin
            in_cnt_d = in_cnt_q;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rim_cnt_q     <= CNT_ZERO;
         in_cnt_q      <= CNT_ZERO;
         frame_valid_q <= 1'b0;
      end else begin
         rim_cnt_q <= rim_cnt_d;
         in_cnt_q  <= in_cnt_d;
         if (sof_i) begin
            frame_valid_q <= 1'b1;
         end
      end
   end

   // Rim contact outranks interior overlap.
   always_comb begin
      class_s = CLS_PARTIAL;
      if (rim_cnt_q >= RIM_TH) begin
         class_s = CLS_RIM;
      end else if (in_cnt_q >= IN_TH) begin
         class_s = CLS_IN;
      end else if ((rim_cnt_q == CNT_ZERO) && (in_cnt_q == CNT_ZERO)) begin
         class_s = CLS_CLEAR;
      end else begin
         class_s = CLS_PARTIAL;
      end
   end

   assign class_o       = class_s;
   assign class_valid_o = sof_i & frame_valid_q;

endmodule

// File: rtl/hoop_pass_detector.sv
// Decides hoop pass-through or rim crash across frames and pulses the result to game control.
module hoop_pass_detector
   import hoop_pkg::*;
#(
   parameter int CNT_W             = CNT_W_DEF,
   parameter int IN_THRESH         = IN_THRESH_DEF,
   parameter int RIM_THRESH        = RIM_THRESH_DEF,
   parameter int MIN_INSIDE_FRAMES = MIN_INSIDE_FRAMES_DEF,
   parameter int COOLDOWN_FRAMES   = COOLDOWN_FRAMES_DEF
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       startOfFrame,
   input  logic       playerDrawingRequest,
   input  logic       hoopInsideRect,
   input  logic       hoopTopDrawingRequest,
   input  logic       hoopBotDrawingRequest,
   output logic       passPulse,
   output logic       crashPulse,
   output logic [7:0] passCount,
   output logic       busy
);

   localparam logic [7:0] MIN_IN   = 8'(MIN_INSIDE_FRAMES);
   localparam logic [7:0] CD_LIMIT = 8'(COOLDOWN_FRAMES);

   logic         rim_pix_s, in_pix_s, class_valid_s;
   frame_class_t frame_class_s;
   hoop_state_t  state_q;
   logic [7:0]   inside_frames_q, cd_cnt_q, pass_count_q, cd_inc_s;
   logic         pass_pulse_q, crash_pulse_q, busy_q;

   assign rim_pix_s = playerDrawingRequest & (hoopTopDrawingRequest | hoopBotDrawingRequest);
   assign in_pix_s  = playerDrawingRequest & hoopInsideRect &
                      ~hoopTopDrawingRequest & ~hoopBotDrawingRequest;
   assign cd_inc_s  = cd_cnt_q + 8'd1;

   frame_overlap_counter #(
      .CNT_W      (CNT_W),
      .IN_THRESH  (IN_THRESH),
      .RIM_THRESH (RIM_THRESH)
   ) u_counter (
      .clk_i         (clk),
      .rst_i         (resetN),
      .sof_i         (startOfFrame),
      .rim_pix_i     (rim_pix_s),
      .in_pix_i      (in_pix_s),
      .class_o       (frame_class_s),
      .class_valid_o (class_valid_s)
   );

   // Acts on the startOfFrame cycle so pulses appear on the very next cycle.
   always_ff @(posedge clk or posedge resetN) begin
      if (resetN) begin
         state_q         <= IDLE;
         inside_frames_q <= 8'd0;
         cd_cnt_q        <= 8'd0;
         pass_count_q    <= 8'd0;
         pass_pulse_q    <= 1'b0;
         crash_pulse_q   <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         pass_pulse_q  <= 1'b0;
         crash_pulse_q <= 1'b0;
         if (class_valid_s) begin
            case (state_q)
               IDLE: begin
                  if (frame_class_s == CLS_RIM) begin
                     crash_pulse_q <= 1'b1;
                     cd_cnt_q      <= 8'd0;
                     state_q       <= COOLDOWN;
                     busy_q        <= 1'b1;
                  end else if (frame_class_s == CLS_IN) begin
                     inside_frames_q <= 8'd1;
                     state_q         <= INSIDE;
                     busy_q          <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end
               INSIDE: begin
                  case (frame_class_s)
                     CLS_RIM: begin
                        crash_pulse_q <= 1'b1;
                        cd_cnt_q      <= 8'd0;
                        state_q       <= COOLDOWN;
                        busy_q        <= 1'b1;
                     end
                     CLS_CLEAR: begin
                        // Too few inside frames means the player only grazed the hoop area.
                        if (inside_frames_q >= MIN_IN) begin
                           pass_pulse_q <= 1'b1;
                           pass_count_q <= sat_inc8(pass_count_q);
                           cd_cnt_q     <= 8'd0;
                           state_q      <= COOLDOWN;
                           busy_q       <= 1'b1;
                        end else begin
                           state_q <= IDLE;
                           busy_q  <= 1'b0;
                        end
                     end
                     CLS_IN, CLS_PARTIAL: begin
                        inside_frames_q <= sat_inc8(inside_frames_q);
                     end
                     default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                     end
                  endcase
               end
               COOLDOWN: begin
                  if (cd_inc_s == CD_LIMIT) begin
                     cd_cnt_q <= 8'd0;
                     state_q  <= IDLE;
                     busy_q   <= 1'b0;
                  end else begin
                     cd_cnt_q <= cd_inc_s;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign passPulse  = pass_pulse_q;
   assign crashPulse = crash_pulse_q;
   assign passCount  = pass_count_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_hoop_pass_detector.sv
// Scoreboard bench for hoop_pass_detector: a frame-level model queues expected outputs at each startOfFrame.
module tb_hoop_pass_detector;

   logic       clk;
   logic       resetN;
   logic       startOfFrame;
   logic       playerDrawingRequest;
   logic       hoopInsideRect;
   logic       hoopTopDrawingRequest;
   logic       hoopBotDrawingRequest;
   logic       passPulse;
   logic       crashPulse;
   logic [7:0] passCount;
   logic       busy;

   hoop_pass_detector dut (
      .clk                   (clk),
      .resetN                (resetN),
      .startOfFrame          (startOfFrame),
      .playerDrawingRequest  (playerDrawingRequest),
      .hoopInsideRect        (hoopInsideRect),
      .hoopTopDrawingRequest (hoopTopDrawingRequest),
      .hoopBotDrawingRequest (hoopBotDrawingRequest),
      .passPulse             (passPulse),
      .crashPulse            (crashPulse),
      .passCount             (passCount),
      .busy                  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       pass;
      logic       crash;
      logic [7:0] count;
      logic       busy;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // reference model state
   bit   m_valid;
   int   m_state;
   int   m_inside;
   int   m_cd;
   int   m_count;
   int   m_in;
   int   m_rim;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0; m_state = 0; m_inside = 0; m_cd = 0; m_count = 0; m_in = 0; m_rim = 0;
   endtask

   // class codes: 0 clear, 1 partial, 2 in, 3 rim
   task automatic model_sof();
      exp_t e;
      int   cls;
      e.pass = 1'b0;
      e.crash = 1'b0;
      if (!m_valid) begin
         m_valid = 1'b1;
      end else begin
         if (m_rim >= 4) cls = 3;
         else if (m_in >= 32) cls = 2;
         else if (m_rim == 0 && m_in == 0) cls = 0;
         else cls = 1;
         case (m_state)
            0: begin
               if (cls == 3) begin e.crash = 1'b1; m_state = 2; m_cd = 0; end
               else if (cls == 2) begin m_inside = 1; m_state = 1; end
            end
            1: begin
               if (cls == 3) begin e.crash = 1'b1; m_state = 2; m_cd = 0; end
               else if (cls == 0) begin
                  if (m_inside >= 3) begin
                     e.pass = 1'b1;
                     m_count = (m_count == 255) ? 255 : m_count + 1;
                     m_state = 2; m_cd = 0;
                  end else begin
                     m_state = 0;
                  end
               end else begin
                  m_inside = (m_inside == 255) ? 255 : m_inside + 1;
               end
            end
            default: begin
               m_cd++;
               if (m_cd == 30) begin m_state = 0; m_cd = 0; end
            end
         endcase
      end
      m_in = 0;
      m_rim = 0;
      e.count = 8'(m_count);
      e.busy = (m_state != 0);
      exp_q.push_back(e);
   endtask

   // kind: 0 none, 1 interior, 2 top rim, 3 bottom rim, 4 player outside rect, 5 rect without player
   task automatic cyc(input logic sof, input int kind);
      @(negedge clk);
      startOfFrame          = sof;
      playerDrawingRequest  = (kind >= 1 && kind <= 4);
      hoopInsideRect        = (kind == 1 || kind == 2 || kind == 3 || kind == 5);
      hoopTopDrawingRequest = (kind == 2);
      hoopBotDrawingRequest = (kind == 3);
      @(posedge clk);
      if (sof) model_sof();
      if (kind == 1) m_in++;
      if (kind == 2 || kind == 3) m_rim++;
   endtask

   task automatic frame(input int n_in, input int n_rim, input int n_noise);
      cyc(1'b1, 0);
      for (int i = 0; i < n_in; i++) cyc(1'b0, 1);
      for (int i = 0; i < n_rim; i++) cyc(1'b0, 2 + (i % 2));
      for (int i = 0; i < n_noise; i++) cyc(1'b0, 4 + (i % 2));
   endtask

   task automatic empty_frames(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 0);
   endtask

   // Compare the DUT against the queued model result on the cycle after each startOfFrame.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("pass", passPulse, e.pass);
         chk("crash", crashPulse, e.crash);
         chk("count", passCount, e.count);
         chk("busy", busy, e.busy);
      end else begin
         chk("pass_quiet", passPulse, 1'b0);
         chk("crash_quiet", crashPulse, 1'b0);
      end
   end

   initial begin
      resetN = 1'b1;
      startOfFrame = 1'b0;
      playerDrawingRequest = 1'b0;
      hoopInsideRect = 1'b0;
      hoopTopDrawingRequest = 1'b0;
      hoopBotDrawingRequest = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_pass", passPulse, 1'b0);
      chk("rst_crash", crashPulse, 1'b0);
      chk("rst_count", passCount, 8'd0);
      chk("rst_busy", busy, 1'b0);
      resetN = 1'b0;

      // partial frame before the first SOF is discarded
      for (int i = 0; i < 100; i++) cyc(1'b0, 1);
      frame(40, 0, 3);
      frame(40, 0, 0);
      frame(40, 0, 0);
      frame(0, 0, 0);
      frame(0, 0, 0);
      #1 chk("pass_sof5", passPulse, 1'b1);
      empty_frames(30);
      cyc(1'b0, 0);
      chk("count_one", passCount, 8'd1);
      chk("idle_after_cd", busy, 1'b0);

      // rim wins over interior overlap
      frame(50, 5, 0);
      frame(0, 0, 0);
      #1 chk("crash_rim_wins", crashPulse, 1'b1);
      empty_frames(29);
      cyc(1'b0, 0);
      chk("busy_cd29", busy, 1'b1);
      empty_frames(1);
      cyc(1'b0, 0);
      chk("idle_cd30", busy, 1'b0);

      // glancing touch: only two inside frames
      frame(40, 0, 0);
      frame(40, 0, 0);
      frame(0, 0, 0);
      frame(0, 0, 0);
      cyc(1'b0, 0);
      chk("glance_idle", busy, 1'b0);
      chk("glance_count", passCount, 8'd1);

      // 3 rim pixels is below threshold; SOF-coincident pixel goes to the new frame
      frame(0, 3, 0);
      frame(31, 0, 0);
      cyc(1'b1, 1);
      for (int i = 0; i < 31; i++) cyc(1'b0, 1);
      cyc(1'b1, 0);
      cyc(1'b0, 1);
      cyc(1'b0, 1);
      chk("busy_inside", busy, 1'b1);

      // asynchronous reset mid-frame while INSIDE
      @(negedge clk);
      #2 resetN = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_count", passCount, 8'd0);
      chk("mid_rst_pass", passPulse, 1'b0);
      chk("mid_rst_crash", crashPulse, 1'b0);
      startOfFrame = 1'b0;
      playerDrawingRequest = 1'b0;
      hoopInsideRect = 1'b0;
      model_reset();
      exp_q.delete();
      repeat (2) @(negedge clk);
      resetN = 1'b0;

      // saturate passCount with 256 minimum-threshold passes
      cyc(1'b1, 0);
      for (int k = 0; k < 256; k++) begin
         frame(32, 0, 0);
         frame(32, 0, 0);
         frame(32, 0, 0);
         frame(0, 0, 0);
         frame(0, 0, 0);
         if (k == 255) begin
            #1 chk("pass_256", passPulse, 1'b1);
         end
         empty_frames(30);
      end
      cyc(1'b0, 0);
      cyc(1'b0, 0);
      chk("count_sat", passCount, 8'd255);
      chk("final_idle", busy, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
